// File: rtl/of_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : of_hazard_controller
//  Description : Operand-fetch hazard controller for a 5-stage in-order pipe.
//                Tracks in-flight destination registers in a 3-slot
//                scoreboard (EX, MA, RW) and stalls the OF instruction while
//                any of its sources is still in flight. A taken branch from
//                EX overrides everything and flushes IF/OF and OF/EX.
//  Ports       : clk, reset            - clock, sync active-high reset
//                of_valid/of_rs1/of_rs2/of_uses_rs1/of_uses_rs2/
//                of_writes_rd/of_rd    - decoded OF-stage instruction
//                branch_taken          - EX resolved a taken branch
//                pc_write_en, if_of_write_en, bubble_ex, flush_if_of
//                                      - pipeline control
//                state                 - 00 RUN, 01 STALL, 10 FLUSH
//                stall_count           - saturating count of stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module of_hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        of_valid,
    input  logic [3:0]  of_rs1,
    input  logic [3:0]  of_rs2,
    input  logic        of_uses_rs1,
    input  logic        of_uses_rs2,
    input  logic        of_writes_rd,
    input  logic [3:0]  of_rd,
    input  logic        branch_taken,
    output logic        pc_write_en,
    output logic        if_of_write_en,
    output logic        bubble_ex,
    output logic        flush_if_of,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;

    // Scoreboard slots: one per downstream stage that has not yet written back
    logic        r_ex_v, r_ma_v, r_rw_v;
    logic [3:0]  r_ex_rd, r_ma_rd, r_rw_rd;
    logic [15:0] r_stall_count;

    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_hazard;
    logic        w_new_ex_v;

    // A source hits if any valid in-flight slot will write that register;
    // several simultaneous hits collapse into one hazard bit.
    assign w_rs1_hit = (r_ex_v && (r_ex_rd == of_rs1)) ||
                       (r_ma_v && (r_ma_rd == of_rs1)) ||
                       (r_rw_v && (r_rw_rd == of_rs1));
    assign w_rs2_hit = (r_ex_v && (r_ex_rd == of_rs2)) ||
                       (r_ma_v && (r_ma_rd == of_rs2)) ||
                       (r_rw_v && (r_rw_rd == of_rs2));
    assign w_hazard  = of_valid && ((of_uses_rs1 && w_rs1_hit) ||
                                    (of_uses_rs2 && w_rs2_hit));

    // Next state and pipeline controls
    always_comb begin
        w_next_state   = ST_RUN;
        pc_write_en    = 1'b1;
        if_of_write_en = 1'b1;
        bubble_ex      = 1'b0;
        flush_if_of    = 1'b0;

        if (branch_taken) begin
            w_next_state = ST_FLUSH;
        end else if (r_state == ST_FLUSH) begin
            w_next_state = ST_RUN;
        end else if (w_hazard) begin
            w_next_state = ST_STALL;
        end

        if (reset) begin
            // Hold the front end and squash both pipeline registers
            pc_write_en    = 1'b0;
            if_of_write_en = 1'b0;
            bubble_ex      = 1'b1;
            flush_if_of    = 1'b1;
        end else if (branch_taken) begin
            bubble_ex      = 1'b1;
            flush_if_of    = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            // The OF instruction is on the wrong path; its hazard is moot
            bubble_ex      = 1'b1;
        end else if (w_hazard) begin
            pc_write_en    = 1'b0;
            if_of_write_en = 1'b0;
            bubble_ex      = 1'b1;
        end
    end

    // A bubble enters EX as an empty slot so it never blocks a later reader
    assign w_new_ex_v = of_valid && of_writes_rd && !bubble_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_ex_v        <= 1'b0;
            r_ma_v        <= 1'b0;
            r_rw_v        <= 1'b0;
            r_ex_rd       <= 4'd0;
            r_ma_rd       <= 4'd0;
            r_rw_rd       <= 4'd0;
            r_stall_count <= 16'd0;
        end else begin
            r_state <= w_next_state;
            r_ex_v  <= w_new_ex_v;
            r_ex_rd <= of_rd;
            r_ma_v  <= r_ex_v;
            r_ma_rd <= r_ex_rd;
            r_rw_v  <= r_ma_v;
            r_rw_rd <= r_ma_rd;
            if (!pc_write_en && (r_stall_count != C_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
